// File: rtl/vga_rx_monitor.sv
// VGA receive-side monitor: recovers pixel phase and X/Y from hsync/vsync/RGB,
// verifies frame timing, and streams captured active pixels once locked.
module vga_rx_monitor #(
    parameter int unsigned CLK_PER_PIX = 2,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned V_FP        = 10
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [3:0]  pix_r,
    output logic [3:0]  pix_g,
    output logic [3:0]  pix_b,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_cnt,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines
);

    localparam int unsigned PH_W = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_PER_PIX - 1);
    localparam logic [PH_W-1:0] PH_START = (CLK_PER_PIX > 1) ? PH_W'(1) : '0;
    localparam logic [11:0] HC_START = (CLK_PER_PIX > 1) ? 12'd0 : 12'd1;
    localparam logic [11:0] H_TOTAL  = 12'(H_SYNC + H_BP + H_ACT + H_FP);
    localparam logic [11:0] H_ACT0   = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_ACT1   = 12'(H_SYNC + H_BP + H_ACT);
    localparam logic [10:0] V_TOTAL  = 11'(V_SYNC + V_BP + V_ACT + V_FP);
    localparam logic [10:0] V_ACT0   = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT1   = 11'(V_SYNC + V_BP + V_ACT);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

    state_e          state_q;
    logic            hs_q, vs_q, hs_p, vs_p;
    logic [11:0]     rgb_q;
    logic [PH_W-1:0] ph_q;
    logic [11:0]     hcnt_q;
    logic [10:0]     vcnt_q;
    logic            armed_q, bad_q;

    logic       hs_fall, vs_fall, samp, h_act, v_act, pix_hit, viol;
    logic [7:0] err_inc;

    always_comb begin
        hs_fall = hs_p & ~hs_q;
        vs_fall = vs_p & ~vs_q;
        // The fall cycle is phase 0 of pixel 0, so it is never a sample cycle.
        samp    = !hs_fall && (ph_q == PH_LAST);
        h_act   = (hcnt_q >= H_ACT0) && (hcnt_q < H_ACT1);
        v_act   = (vcnt_q >= V_ACT0) && (vcnt_q < V_ACT1);
        pix_hit = (state_q == StLocked) && samp && h_act && v_act;
        err_inc = (err_cnt != 8'hff) ? err_cnt + 8'd1 : err_cnt;
        // hcnt_q holds the completed pixel count when the next hsync falls.
        viol = (state_q != StSearch) && armed_q &&
               ((hs_fall && (hcnt_q != H_TOTAL)) ||
                (!hs_fall && (hcnt_q == H_TOTAL) && (ph_q == '0)) ||
                (vs_fall && ((vcnt_q + 11'd1) != V_TOTAL)) ||
                (hs_fall && !vs_fall && (vcnt_q == V_TOTAL - 11'd1)));
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSearch;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            hs_p        <= 1'b0;
            vs_p        <= 1'b0;
            rgb_q       <= '0;
            ph_q        <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            armed_q     <= 1'b0;
            bad_q       <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            err_cnt     <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            hs_q  <= hsync;
            vs_q  <= vsync;
            hs_p  <= hs_q;
            vs_p  <= vs_q;
            rgb_q <= {vga_r, vga_g, vga_b};

            if (hs_fall) begin
                ph_q     <= PH_START;
                hcnt_q   <= HC_START;
                line_len <= hcnt_q;
            end else if (ph_q == PH_LAST) begin
                ph_q <= '0;
                if (hcnt_q != 12'hfff) hcnt_q <= hcnt_q + 12'd1;
            end else begin
                ph_q <= ph_q + PH_W'(1);
            end

            if (vs_fall) begin
                vcnt_q      <= '0;
                frame_lines <= vcnt_q + 11'd1;
            end else if (hs_fall && (vcnt_q != 11'h7ff)) begin
                vcnt_q <= vcnt_q + 11'd1;
            end

            pix_valid   <= pix_hit;
            frame_start <= pix_hit && (hcnt_q == H_ACT0) && (vcnt_q == V_ACT0);
            if (pix_hit) begin
                pix_x                 <= 10'(hcnt_q - H_ACT0);
                pix_y                 <= 10'(vcnt_q - V_ACT0);
                {pix_r, pix_g, pix_b} <= rgb_q;
            end

            sync_err <= 1'b0;
            unique case (state_q)
                StSearch: begin
                    if (vs_fall) begin
                        state_q <= StMeasure;
                        armed_q <= 1'b0;
                        bad_q   <= 1'b0;
                    end
                end
                StMeasure: begin
                    // The line in progress at entry is partial, so checks start at the next hs fall.
                    if (hs_fall) armed_q <= 1'b1;
                    if (viol) begin
                        sync_err <= 1'b1;
                        err_cnt  <= err_inc;
                    end
                    if (vs_fall) begin
                        bad_q <= 1'b0;
                        if (armed_q && !bad_q && !viol) begin
                            state_q <= StLocked;
                            locked  <= 1'b1;
                        end
                    end else if (viol) begin
                        bad_q <= 1'b1;
                    end
                end
                StLocked: begin
                    if (viol) begin
                        state_q  <= StSearch;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                        err_cnt  <= err_inc;
                        armed_q  <= 1'b0;
                    end
                end
                default: state_q <= StSearch;
            endcase
        end
    end

endmodule
